// File: rtl/seq_adder_sub.sv
// Multi-cycle adder/subtractor: processes SLICE bits of a WIDTH-bit operation per clock.
// Optional zero-result flag output enabled by defining SEQ_ADDER_ZERO_FLAG_EN.
module seq_adder_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             last;
    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sl_res;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // A request is only taken while no operation is in flight (IDLE or DONE).
    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
        sl_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (cnt_q == CW'(i)) begin
                    sum_d[i*SLICE +: SLICE] = sl_res[SLICE-1:0];
                end
            end
            carry_d = sl_res[SLICE];
            cnt_d   = cnt_q + CW'(1);
            // Flags use the sum including the slice being written on this edge.
            if (last) begin
                cout_d = sl_res[SLICE];
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`ifdef SEQ_ADDER_ZERO_FLAG_EN
                zero_d = (sum_d == '0);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_seq_adder_sub.sv
// Randomized self-checking bench for seq_adder_sub (16/4 and 8/1 instances).
module tb_seq_adder_sub;

    logic        clk;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b, sum;
    logic        cout, ovf, busy, done;
    logic        start2, sub2, cin2;
    logic [7:0]  a2, b2, sum2;
    logic        cout2, ovf2, busy2, done2;
`ifdef SEQ_ADDER_ZERO_FLAG_EN
    logic        zero, zero2;
`endif

    int checks = 0;
    int errors = 0;

    seq_adder_sub #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    seq_adder_sub #(.WIDTH(8), .SLICE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        , .zero(zero2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; overflow as a signed range check.
    function automatic void model(input int w, input longint av, input longint bv,
                                  input logic sv, input logic cv,
                                  output longint es, output logic ec, output logic eo);
        longint m, sa, sb, sr, full;
        m  = longint'(1) << w;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (!sv) begin
            full = av + bv + longint'(cv);
            es   = full % m;
            ec   = (full >= m);
            sr   = sa + sb + longint'(cv);
        end else begin
            es = (av - bv + m) % m;
            ec = (av >= bv);
            sr = sa - sb;
        end
        eo = (sr >= m / 2) || (sr < -(m / 2));
    endfunction

    task automatic wait_done(output int cyc, output logic busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 64) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv);
        longint es; logic ec, eo; int cyc; logic busy_ok;
        model(16, longint'(av), longint'(bv), sv, cv, es, ec, eo);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, busy_ok);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL latency16 got %0d want 4", cyc); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL busy16 got low during run want high"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_done16 got %b want 0", busy); end
        checks++; if (sum !== es[15:0]) begin errors++; $display("FAIL sum16 a=%h b=%h sub=%b got %h want %h", av, bv, sv, sum, es[15:0]); end
        checks++; if (cout !== ec) begin errors++; $display("FAIL cout16 a=%h b=%h sub=%b got %b want %b", av, bv, sv, cout, ec); end
        checks++; if (ovf !== eo) begin errors++; $display("FAIL ovf16 a=%h b=%h sub=%b got %b want %b", av, bv, sv, ovf, eo); end
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        checks++; if (zero !== (es == 0)) begin errors++; $display("FAIL zero16 got %b want %b", zero, (es == 0)); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse16 got %b want 0", done); end
        checks++; if (sum !== es[15:0]) begin errors++; $display("FAIL sum_hold16 got %h want %h", sum, es[15:0]); end
    endtask

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, input logic cv);
        longint es; logic ec, eo; int cyc;
        model(8, longint'(av), longint'(bv), sv, cv, es, ec, eo);
        @(negedge clk);
        a2 = av; b2 = bv; sub2 = sv; cin2 = cv; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL latency8 got %0d want 8", cyc); end
        checks++; if (sum2 !== es[7:0]) begin errors++; $display("FAIL sum8 a=%h b=%h sub=%b got %h want %h", av, bv, sv, sum2, es[7:0]); end
        checks++; if (cout2 !== ec) begin errors++; $display("FAIL cout8 got %b want %b", cout2, ec); end
        checks++; if (ovf2 !== eo) begin errors++; $display("FAIL ovf8 got %b want %b", ovf2, eo); end
`ifdef SEQ_ADDER_ZERO_FLAG_EN
        checks++; if (zero2 !== (es == 0)) begin errors++; $display("FAIL zero8 got %b want %b", zero2, (es == 0)); end
`endif
        @(negedge clk);
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL done_pulse8 got %b want 0", done2); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
        checks++; if ({cout, ovf, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {cout, ovf, busy, done}); end
        checks++; if ({sum2, cout2, ovf2, busy2, done2} !== 12'h0) begin errors++; $display("FAIL reset_dut2 got %h want 000", {sum2, cout2, ovf2, busy2, done2}); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] av, bv;
        for (int i = 0; i < 30; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if (i % 7 == 0) bv = av;
            run_op(av, bv, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic busy_ok;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        wait_done(cyc, busy_ok);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL ignore_latency got %0d want 2", cyc); end
        checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL ignore_sum got %h want 0002", sum); end
        a = 16'h0003; b = 16'h0004; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL b2b_accept done/busy got %b want 01", {done, busy}); end
        wait_done(cyc, busy_ok);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", cyc); end
        checks++; if (sum !== 16'h0007) begin errors++; $display("FAIL b2b_sum got %h want 0007", sum); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic saw_done;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL abort_sum got %h want 0000", sum); end
        checks++; if ({cout, ovf, busy, done} !== 4'b0) begin errors++; $display("FAIL abort_flags got %b want 0000", {cout, ovf, busy, done}); end
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_nodone got activity want idle"); end
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_slice1();
        run_op8(8'h7F, 8'h00, 1'b0, 1'b1);
        run_op8(8'h80, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        test_slice1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
